// File: rtl/butterfly_pkg.sv
// Shared twiddle constants and helpers for the radix-4 butterfly.
// The W16 table is quantised at 8 fraction bits and rescaled to the datapath FRAC.
package butterfly_pkg;

  localparam int TW_QFRAC = 8;

  typedef struct packed {
    logic       second;  // second stage: no twiddle
    logic [1:0] grp;     // first-stage group k
  } rot_t;

  function automatic int tw_cos8(input int n);
    case (n)
      0: return 256;
      1: return 237;
      2: return 181;
      3: return 98;
      4: return 0;
      5: return -98;
      6: return -181;
      7: return -237;
      8: return -256;
      9: return -237;
      default: return 0;
    endcase
  endfunction

  function automatic int tw_sin8(input int n);
    case (n)
      0: return 0;
      1: return 98;
      2: return 181;
      3: return 237;
      4: return 256;
      5: return 237;
      6: return 181;
      7: return 98;
      8: return 0;
      9: return -98;
      default: return 0;
    endcase
  endfunction

  function automatic int tw_rescale(input int v, input int frac);
    if (frac >= TW_QFRAC) return v * (1 << (frac - TW_QFRAC));
    return v >>> (TW_QFRAC - frac);
  endfunction

  // Index n of W16^n applied to output ym; index 0 (exactly 1.0) doubles as bypass.
  function automatic int tw_idx(input int m, input rot_t rot);
    return rot.second ? 0 : m * int'(rot.grp);
  endfunction

endpackage

// File: rtl/butterfly_r4_pipe_if.sv
// Input and output valid/ready channels of the radix-4 butterfly.
interface butterfly_r4_pipe_if #(parameter int DW = 17);
  logic            in_valid;
  logic            in_ready;
  logic [8*DW-1:0] calc_in;
  logic [2:0]      rotation;
  logic            out_valid;
  logic            out_ready;
  logic [8*DW-1:0] calc_out;
  logic            ovf;

  modport master (output in_valid, calc_in, rotation, out_ready,
                  input  in_ready, out_valid, calc_out, ovf);
  modport slave  (input  in_valid, calc_in, rotation, out_ready,
                  output in_ready, out_valid, calc_out, ovf);
endinterface

// File: rtl/butterfly_cmul.sv
// Complex multiply a * (cos - j sin) with round-half-up to FRAC fraction bits.
// Purely combinational; output carries 3 guard bits above AW.
module butterfly_cmul #(
  parameter int AW   = 19,
  parameter int FRAC = 8
) (
  input  logic signed [AW-1:0]   a_re,
  input  logic signed [AW-1:0]   a_im,
  input  logic signed [FRAC+1:0] w_cos,
  input  logic signed [FRAC+1:0] w_sin,
  output logic signed [AW+2:0]   p_re,
  output logic signed [AW+2:0]   p_im
);
  localparam int PW = AW + FRAC + 3;
  localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC - 1);

  logic signed [PW-1:0] ar, ai, wc, ws, re_full, im_full;
  logic                 unused_lsbs;

  assign ar = PW'(a_re);
  assign ai = PW'(a_im);
  assign wc = PW'(w_cos);
  assign ws = PW'(w_sin);

  assign re_full = ar * wc + ai * ws + RND;
  assign im_full = ai * wc - ar * ws + RND;

  assign p_re = re_full[PW-1:FRAC];
  assign p_im = im_full[PW-1:FRAC];
  assign unused_lsbs = ^{re_full[FRAC-1:0], im_full[FRAC-1:0]};
endmodule

// File: rtl/butterfly_r4_pipe.sv
// 3-stage radix-4 DIF butterfly (capture, add/sub, twiddle+narrow), global stall on out_ready.
// BUTTERFLY_SAT_EN: saturate out-of-range components instead of wrapping.
module butterfly_r4_pipe
  import butterfly_pkg::*;
#(
  parameter int DW   = 17,
  parameter int FRAC = 8
) (
  input logic               clk,
  input logic               rst_n,
  butterfly_r4_pipe_if.slave bus
);
  localparam int SW = DW + 2;
  localparam int PW = SW + 3;

  logic en;

  logic            s1_vld;
  logic [8*DW-1:0] s1_dat;
  rot_t            s1_rot;

  logic                 s2_vld;
  rot_t                 s2_rot;
  logic signed [SW-1:0] s2_yr [4];
  logic signed [SW-1:0] s2_yi [4];

  logic            s3_vld;
  logic [8*DW-1:0] s3_dat;
  logic            s3_ovf;

  logic signed [SW-1:0] xr [4];
  logic signed [SW-1:0] xi [4];
  logic signed [PW-1:0] p_re [4];
  logic signed [PW-1:0] p_im [4];
  logic [8*DW-1:0]      nxt_dat;
  logic                 nxt_ovf;

  assign en           = !s3_vld || bus.out_ready;
  assign bus.in_ready = en && rst_n;
  assign bus.out_valid = s3_vld;
  assign bus.calc_out  = s3_dat;
  assign bus.ovf       = s3_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
    end else if (en) begin
      s1_vld <= bus.in_valid;
      s1_dat <= bus.calc_in;
      s1_rot <= rot_t'(bus.rotation);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      xr[i] = SW'($signed(s1_dat[(8-2*i)*DW-1 -: DW]));
      xi[i] = SW'($signed(s1_dat[(7-2*i)*DW-1 -: DW]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
    end else if (en) begin
      s2_vld   <= s1_vld;
      s2_rot   <= s1_rot;
      s2_yr[0] <= xr[0] + xr[1] + xr[2] + xr[3];
      s2_yi[0] <= xi[0] + xi[1] + xi[2] + xi[3];
      s2_yr[1] <= xr[0] + xi[1] - xr[2] - xi[3];
      s2_yi[1] <= xi[0] - xr[1] - xi[2] + xr[3];
      s2_yr[2] <= xr[0] - xr[1] + xr[2] - xr[3];
      s2_yi[2] <= xi[0] - xi[1] + xi[2] - xi[3];
      s2_yr[3] <= xr[0] - xi[1] - xr[2] + xi[3];
      s2_yi[3] <= xi[0] + xr[1] - xi[2] - xr[3];
    end
  end

  for (genvar m = 0; m < 4; m++) begin : g_cmul
    logic signed [FRAC+1:0] w_cos, w_sin;
    assign w_cos = (FRAC+2)'(tw_rescale(tw_cos8(tw_idx(m, s2_rot)), FRAC));
    assign w_sin = (FRAC+2)'(tw_rescale(tw_sin8(tw_idx(m, s2_rot)), FRAC));

    butterfly_cmul #(.AW(SW), .FRAC(FRAC)) u_cmul (
      .a_re  (s2_yr[m]),
      .a_im  (s2_yi[m]),
      .w_cos (w_cos),
      .w_sin (w_sin),
      .p_re  (p_re[m]),
      .p_im  (p_im[m])
    );
  end

  function automatic logic fits(input logic [PW-1:0] v);
    return (&v[PW-1:DW-1]) || !(|v[PW-1:DW-1]);
  endfunction

  function automatic logic [DW-1:0] narrow(input logic [PW-1:0] v);
`ifdef BUTTERFLY_SAT_EN
    if (!fits(v)) return v[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
    return v[DW-1:0];
  endfunction

  always_comb begin
    nxt_dat = '0;
    nxt_ovf = 1'b0;
    for (int m = 0; m < 4; m++) begin
      nxt_dat[(8-2*m)*DW-1 -: DW] = narrow(p_re[m]);
      nxt_dat[(7-2*m)*DW-1 -: DW] = narrow(p_im[m]);
      nxt_ovf = nxt_ovf | !fits(p_re[m]) | !fits(p_im[m]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_vld <= 1'b0;
      s3_dat <= '0;
      s3_ovf <= 1'b0;
    end else if (en) begin
      s3_vld <= s2_vld;
      s3_dat <= nxt_dat;
      s3_ovf <= nxt_ovf;
    end
  end
endmodule

// File: tb/tb_butterfly_r4_pipe.sv
// Scoreboard bench for butterfly_r4_pipe: arithmetic reference model, random traffic and backpressure.
module tb_butterfly_r4_pipe;
  localparam int DW   = 17;
  localparam int FRAC = 8;
  localparam real PI  = 3.14159265358979;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  butterfly_r4_pipe_if #(.DW(DW)) bus ();
  butterfly_r4_pipe #(.DW(DW), .FRAC(FRAC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  logic [8*DW:0] exp_q [$];
  logic rnd_done;

  task automatic check(input string name, input logic [8*DW-1:0] act, input logic [8*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8*DW-1:0] pk(int r0, int i0, int r1, int i1, int r2, int i2, int r3, int i3);
    return {DW'(r0), DW'(i0), DW'(r1), DW'(i1), DW'(r2), DW'(i2), DW'(r3), DW'(i3)};
  endfunction

  function automatic bit out_of_range(input longint v);
    return (v > longint'((1 << (DW-1)) - 1)) || (v < -longint'(1 << (DW-1)));
  endfunction

  function automatic logic [DW-1:0] to_dw(input longint v);
`ifdef BUTTERFLY_SAT_EN
    if (v > longint'((1 << (DW-1)) - 1)) return DW'((1 << (DW-1)) - 1);
    if (v < -longint'(1 << (DW-1)))      return DW'(1 << (DW-1));
`endif
    return v[DW-1:0];
  endfunction

  // y_m = sum_n x_n (-j)^(mn), then times W16^(m*k) with rounded 8-bit constants.
  function automatic logic [8*DW:0] model(input logic [8*DW-1:0] ci, input logic [2:0] rot);
    longint xr [4], xi [4];
    longint yr, yi, c, s, pr, pim;
    int idx;
    real ang;
    logic [8*DW-1:0] co = '0;
    logic ov = 1'b0;
    for (int n = 0; n < 4; n++) begin
      xr[n] = longint'($signed(ci[(8-2*n)*DW-1 -: DW]));
      xi[n] = longint'($signed(ci[(7-2*n)*DW-1 -: DW]));
    end
    for (int m = 0; m < 4; m++) begin
      yr = 0; yi = 0;
      for (int n = 0; n < 4; n++) begin
        case ((m * n) % 4)
          0: begin yr += xr[n]; yi += xi[n]; end
          1: begin yr += xi[n]; yi -= xr[n]; end
          2: begin yr -= xr[n]; yi -= xi[n]; end
          default: begin yr -= xi[n]; yi += xr[n]; end
        endcase
      end
      idx = rot[2] ? 0 : m * int'(rot[1:0]);
      ang = 2.0 * PI * idx / 16.0;
      c = longint'(256.0 * $cos(ang));
      s = longint'(256.0 * $sin(ang));
      pr  = (yr * c + yi * s + 128) >>> FRAC;
      pim = (yi * c - yr * s + 128) >>> FRAC;
      ov = ov | out_of_range(pr) | out_of_range(pim);
      co[(8-2*m)*DW-1 -: DW] = to_dw(pr);
      co[(7-2*m)*DW-1 -: DW] = to_dw(pim);
    end
    return {co, ov};
  endfunction

  function automatic logic [8*DW-1:0] rnd_ci();
    logic [8*DW-1:0] ci;
    int v;
    for (int k = 0; k < 8; k++) begin
      v = ($urandom_range(0, 1) != 0) ? int'($urandom) : int'($urandom_range(0, 1023)) - 512;
      ci[k*DW +: DW] = v[DW-1:0];
    end
    return ci;
  endfunction

  task automatic send(input logic [8*DW-1:0] ci, input logic [2:0] rot);
    bit acc = 0;
    bus.in_valid = 1'b1;
    bus.calc_in  = ci;
    bus.rotation = rot;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) exp_q.push_back(model(ci, rot));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Single beat into an idle pipe: latency and an independent literal result.
  task automatic lat_beat(input string name, input logic [8*DW-1:0] ci, input logic [2:0] rot,
                          input logic [8*DW-1:0] lit, input logic lit_ovf);
    int k = 0;
    bus.out_ready = 1'b1;
    send(ci, rot);
    for (int t = 1; t <= 10 && k == 0; t++) begin
      @(negedge clk);
      if (bus.out_valid) k = t;
    end
    check({name, "_latency"}, k, 3);
    check({name, "_value"}, bus.calc_out, lit);
    check({name, "_ovf"}, bus.ovf, lit_ovf);
    drain();
  endtask

  // Monitor: pops on every transfer, checks hold during stalls.
  initial begin
    logic prev_stall = 1'b0;
    logic [8*DW-1:0] prev_out = '0;
    logic prev_ovf = 1'b0;
    logic [8*DW:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", bus.out_valid, 1);
          check("stall_hold", bus.calc_out, prev_out);
          check("stall_ovf", bus.ovf, prev_ovf);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", bus.out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            n_pop++;
            check("calc_out", bus.calc_out, e[8*DW:1]);
            check("ovf", bus.ovf, e[0]);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = bus.calc_out;
        prev_ovf   = bus.ovf;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop0;
    bit saw_block;
    logic [DW-1:0] ovf_re;
    bus.in_valid  = 1'b0;
    bus.calc_in   = '0;
    bus.rotation  = 3'b000;
    bus.out_ready = 1'b1;
    rnd_done      = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_calc_out", bus.calc_out, 0);
    check("reset_ovf", bus.ovf, 0);
    check("post_reset_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    lat_beat("impulse", pk(256, 0, 0, 0, 0, 0, 0, 0), 3'b000,
             pk(256, 0, 256, 0, 256, 0, 256, 0), 1'b0);
    lat_beat("dc", pk(256, 0, 256, 0, 256, 0, 256, 0), 3'b100,
             pk(1024, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    lat_beat("twiddle", pk(0, 0, 256, 0, 0, 0, 0, 0), 3'b001,
             pk(256, 0, -98, -237, -181, 181, 237, 98), 1'b0);
`ifdef BUTTERFLY_SAT_EN
    ovf_re = 17'h0FFFF;
`else
    ovf_re = 17'h1FFFC;
`endif
    lat_beat("overflow", pk(65535, 0, 65535, 0, 65535, 0, 65535, 0), 3'b100,
             {ovf_re, {(7*DW){1'b0}}}, 1'b1);

    // Six back-to-back beats with out_ready low in cycles 2..8.
    pop0 = n_pop;
    saw_block = 0;
    fork
      begin
        for (int b = 0; b < 6; b++) send(rnd_ci(), 3'($urandom_range(0, 7)));
      end
      begin
        for (int c = 1; c <= 12; c++) begin
          bus.out_ready = !(c >= 2 && c <= 8);
          @(negedge clk);
          if (!bus.in_ready) saw_block = 1;
          @(posedge clk);
          #1;
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    check("bp_in_ready_dropped", saw_block, 1);
    check("bp_result_count", n_pop - pop0, 6);

    // Random traffic with random downstream stalls.
    fork
      begin
        for (int b = 0; b < 300; b++) begin
          send(rnd_ci(), 3'($urandom_range(0, 7)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight.
    send(rnd_ci(), 3'b010);
    send(rnd_ci(), 3'b111);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midreset_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("midreset_out_valid", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    lat_beat("after_reset", pk(256, 0, 0, 0, 0, 0, 0, 0), 3'b100,
             pk(256, 0, 256, 0, 256, 0, 256, 0), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/butterfly_r4_pipe.md
BUTTERFLY_R4_PIPE -- requirements
Module: butterfly_r4_pipe

Interface
REQ-001 Parameter DW, default 17: per-component sample width; two's complement, 1 sign, DW-1-FRAC integer, FRAC fraction bits.
REQ-002 Parameter FRAC, default 8: fraction bits; 1.0 = 2^FRAC.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  calc_in/rotation hold a beat.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 calc_in  input  8*DW  samples x0..x3; x0 in the top 2*DW bits, Re above Im in each pair.
REQ-008 rotation  input  3  bit2=0: first stage with group k=rotation[1:0]; bit2=1: second stage, no twiddle.
REQ-009 out_valid  output  1  calc_out holds a result.
REQ-010 out_ready  input  1  downstream accepts a result.
REQ-011 calc_out  output  8*DW  results y0..y3, same packing as calc_in.
REQ-012 ovf  output  1  some component of the current result exceeded DW range; qualified by out_valid.

Function
REQ-013 Radix-4 DIF: y0=x0+x1+x2+x3; y1=x0-jx1-x2+jx3; y2=x0-x1+x2-x3; y3=x0+jx1-x2-jx3.
REQ-014 When rotation[2]=0, ym is multiplied by W16^(m*k), where W16^n = cos(2πn/16) - j sin(2πn/16) and m*k ranges 0..9; when rotation[2]=1, ym passes unmultiplied.
REQ-015 Intermediate sums are kept at DW+2 bits with no loss.
REQ-016 Products round half-up: add 2^(FRAC-1), then arithmetic shift right by FRAC.
REQ-017 The final narrowing to DW bits follows REQ-029/REQ-030; ovf=1 if any of the 8 components is out of range.
REQ-018 Pipeline of 3 register stages:
- S1: input capture
- S2: add/subtract network
- S3: twiddle multiply, round, narrow
REQ-019 An accepted beat appears on out_valid exactly 3 cycles later when there is no stall.
REQ-020 Advance enable: en = !out_valid || out_ready. All stages advance only when en=1, and in_ready = en.
REQ-021 A beat is accepted iff in_valid && in_ready. Otherwise S1 loads a bubble (valid=0).
REQ-022 While out_valid=1 && out_ready=0, calc_out, ovf and all stage contents hold stable.
REQ-023 No beat is lost, duplicated or reordered. Throughput is 1 beat/cycle with out_ready held high.
REQ-024 rotation is captured with its beat and travels down the pipeline alongside it.

Reset
REQ-025 With rst_n=0 at a rising edge, all stage valid bits clear, so the next cycle shows out_valid=0, calc_out=0 and ovf=0.
REQ-026 While rst_n=0, in_ready=0 and no beat is accepted.
REQ-027 Reset mid-stream discards all in-flight beats; none emerge after reset is released.
REQ-028 The first accept is possible in the cycle after rst_n returns to 1.

Configuration
REQ-029 With macro BUTTERFLY_SAT_EN defined, an out-of-range component clamps to +(2^(DW-1)-1) or -2^(DW-1).
REQ-030 Without BUTTERFLY_SAT_EN, the component wraps (low DW bits kept); ovf is generated identically in both builds.

Structure
REQ-031 Shared package butterfly_pkg holds the twiddle cos/sin constants for n=0..9 and the function mapping (m,k) to a twiddle index.
- Constants are quantised at FRAC=8 (cos π/8=237, sin π/8=98, cos π/4=181) and rescaled for other FRAC values.
REQ-032 One sub-module, butterfly_cmul:
- complex multiply by a signed (FRAC+2)-bit twiddle, with rounding;
- instantiated four times in S3.

Verification (DW=17, FRAC=8, 1.0=256)
REQ-033 Impulse: x0=256+j0, x1..x3=0, rotation=000, out_ready=1 -> y0..y3 all 256+j0, out_valid exactly 3 cycles after accept, ovf=0.
REQ-034 DC: x0..x3=256+j0, rotation=100 -> y0=1024+j0, y1=y2=y3=0.
REQ-035 Twiddle: x1=256+j0, others 0, rotation=001 -> y0=256, y1=-98-j237, y2=-181+j181.
REQ-036 Overflow: all x=65535+j0, rotation=100:
- y0 Re with BUTTERFLY_SAT_EN: 65535, ovf=1;
- y0 Re without BUTTERFLY_SAT_EN: 0x1FFFC (-4), ovf=1.
REQ-037 Backpressure: 6 beats offered back-to-back, out_ready=0 for cycles 2-8:
- in_ready drops once the pipeline is full;
- calc_out holds stable during the stall;
- all 6 results emerge once each, in order.
REQ-038 Reset mid-stream: rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 from the next cycle; no stale result appears; the next beat has latency 3.
